// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, single borrow flop.
// Valid/ready on both sides; a result is held in DONE until the consumer takes it.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_valid,
    output logic             OUT_ready,
    input  logic [WIDTH-1:0] IN_minuend,
    input  logic [WIDTH-1:0] IN_subtrahend,
    output logic             OUT_valid,
    input  logic             IN_ready,
    output logic [WIDTH-1:0] OUT_diff,
    output logic             OUT_borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] min_sh, sub_sh, diff_q;
    logic             borrow, borrow_q;
    logic [CNT_W-1:0] count;
    logic             d_bit, borrow_nxt;
    logic [WIDTH:0]   res_ext;
    logic             accept, last_bit;

    // Full-subtractor bit: returns {borrow_out, difference}
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic br);
        sub_bit = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
    endfunction

    assign {borrow_nxt, d_bit} = sub_bit(min_sh[0], sub_sh[0], borrow);

    // The minuend register doubles as the result accumulator: each consumed LSB
    // frees the MSB slot, which receives the new difference bit.
    assign res_ext  = {d_bit, min_sh};
    assign accept   = (state == IDLE) && IN_valid;
    assign last_bit = (state == RUN) && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_valid) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    if (IN_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_sh   <= '0;
            sub_sh   <= '0;
            borrow   <= 1'b0;
            count    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            min_sh <= IN_minuend;
            sub_sh <= IN_subtrahend;
            borrow <= 1'b0;
            count  <= '0;
        end else if (state == RUN) begin
            min_sh <= res_ext[WIDTH:1];
            sub_sh <= sub_sh >> 1;
            borrow <= borrow_nxt;
            count  <= count + CNT_W'(1);
            // Output copy updates only at completion so it holds through RUN
            if (last_bit) begin
                diff_q   <= res_ext[WIDTH:1];
                borrow_q <= borrow_nxt;
            end
        end
    end

    assign OUT_ready  = (state == IDLE);
    assign OUT_valid  = (state == DONE);
    assign OUT_diff   = diff_q;
    assign OUT_borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 and WIDTH=1 instances, scoreboard-driven.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] in_min, in_sub;
    logic       out_valid, out_ready, out_borrow;
    logic [7:0] out_diff;

    logic       in_valid1, in_ready1;
    logic [0:0] in_min1, in_sub1;
    logic       out_valid1, out_ready1, out_borrow1;
    logic [0:0] out_diff1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] sb1[$];

    serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .IN_valid(in_valid), .OUT_ready(out_ready),
        .IN_minuend(in_min), .IN_subtrahend(in_sub),
        .OUT_valid(out_valid), .IN_ready(in_ready),
        .OUT_diff(out_diff), .OUT_borrow(out_borrow)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .IN_valid(in_valid1), .OUT_ready(out_ready1),
        .IN_minuend(in_min1), .IN_subtrahend(in_sub1),
        .OUT_valid(out_valid1), .IN_ready(in_ready1),
        .OUT_diff(out_diff1), .OUT_borrow(out_borrow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands for one accept edge (caller is at a negedge in IDLE)
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        in_min   = a;
        in_sub   = b;
        in_valid = 1'b1;
        sb.push_back({8'(a - b), (a < b)});
        @(negedge clk);
        in_valid = 1'b0;
        in_min   = 8'($urandom);
        in_sub   = 8'($urandom);
    endtask

    task automatic wait_valid(output int cyc, output bit ready_seen);
        cyc = 0;
        ready_seen = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (out_ready) ready_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take();
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_diff !== 8'd0 || out_borrow !== 1'b0) begin
            failures++;
            $display("FAIL reset_w8: valid=%b ready=%b diff=%0d borrow=%b, want 0 1 0 0",
                     out_valid, out_ready, out_diff, out_borrow);
        end
        checks++;
        if (out_valid1 !== 1'b0 || out_ready1 !== 1'b1 || out_diff1 !== 1'b0 || out_borrow1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_w1: valid=%b ready=%b diff=%0d borrow=%b, want 0 1 0 0",
                     out_valid1, out_ready1, out_diff1, out_borrow1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   cyc;
        bit   rs;
        exp_t e;
        send(8'd200, 8'd55);
        wait_valid(cyc, rs);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges, want 8", cyc);
        end
        checks++;
        if (rs || out_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_busy: ready high while busy (seen=%b now=%b), want 0", rs, out_ready);
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_diff !== e.d || out_borrow !== e.b || e.d !== 8'd145) begin
            failures++;
            $display("FAIL basic_result: diff=%0d borrow=%b, want %0d %b (145 0)",
                     out_diff, out_borrow, e.d, e.b);
        end
        take();
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_handshake: valid=%b ready=%b, want 0 1", out_valid, out_ready);
        end
    endtask

    task automatic test_arith();
        logic [7:0] av[3] = '{8'd5, 8'd0, 8'd255};
        logic [7:0] bv[3] = '{8'd7, 8'd255, 8'd255};
        int   cyc;
        bit   rs;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            send(av[k], bv[k]);
            wait_valid(cyc, rs);
            e = sb.pop_front();
            checks++;
            if (cyc !== 8 || out_diff !== e.d || out_borrow !== e.b) begin
                failures++;
                $display("FAIL arith_%0d_%0d: lat=%0d diff=%0d borrow=%b, want lat=8 diff=%0d borrow=%b",
                         av[k], bv[k], cyc, out_diff, out_borrow, e.d, e.b);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        bit   rs;
        exp_t e;
        send(8'd33, 8'd44);
        wait_valid(cyc, rs);
        e = sb.pop_front();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom);
            in_min   = 8'($urandom);
            in_sub   = 8'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_diff !== e.d || out_borrow !== e.b) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: valid=%b ready=%b diff=%0d borrow=%b, want 1 0 %0d %b",
                         k, out_valid, out_ready, out_diff, out_borrow, e.d, e.b);
            end
        end
        in_valid = 1'b0;
        take();
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_diff !== e.d || out_borrow !== e.b) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b ready=%b diff=%0d borrow=%b, want 0 1 %0d %b",
                     out_valid, out_ready, out_diff, out_borrow, e.d, e.b);
        end
        send(8'd9, 8'd4);
        wait_valid(cyc, rs);
        e = sb.pop_front();
        checks++;
        if (cyc !== 8 || out_diff !== e.d || out_borrow !== e.b) begin
            failures++;
            $display("FAIL backpressure_next: lat=%0d diff=%0d borrow=%b, want lat=8 diff=%0d borrow=%b",
                     cyc, out_diff, out_borrow, e.d, e.b);
        end
        take();
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[3] = '{8'd100, 8'd1, 8'd128};
        logic [7:0] bv[3] = '{8'd1, 8'd100, 8'd128};
        int got = 0;
        int last = -1;
        in_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int t = 0;
                    in_min   = av[k];
                    in_sub   = bv[k];
                    in_valid = 1'b1;
                    while (!out_ready && t < 40) begin
                        @(negedge clk);
                        t++;
                    end
                    sb.push_back({8'(av[k] - bv[k]), (av[k] < bv[k])});
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                exp_t e;
                for (int c = 0; c < 80 && got < 3; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL b2b_unexpected: result %0d/%b with empty scoreboard",
                                     out_diff, out_borrow);
                        end else begin
                            e = sb.pop_front();
                            if (out_diff !== e.d || out_borrow !== e.b) begin
                                failures++;
                                $display("FAIL b2b_result_%0d: diff=%0d borrow=%b, want %0d %b",
                                         got, out_diff, out_borrow, e.d, e.b);
                            end
                        end
                        if (last >= 0) begin
                            checks++;
                            if (c - last !== 10) begin
                                failures++;
                                $display("FAIL b2b_interval_%0d: got %0d cycles, want 10", got, c - last);
                            end
                        end
                        last = c;
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d results, want 3", got);
        end
        in_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        bit   rs;
        bit   seen = 1'b0;
        exp_t e;
        send(8'd77, 8'd12);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_diff !== 8'd0 || out_borrow !== 1'b0) begin
            failures++;
            $display("FAIL midrun_async: valid=%b ready=%b diff=%0d borrow=%b, want 0 1 0 0",
                     out_valid, out_ready, out_diff, out_borrow);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_valid: valid pulse seen=%b, want 0", seen);
        end
        send(8'd10, 8'd3);
        wait_valid(cyc, rs);
        e = sb.pop_front();
        checks++;
        if (cyc !== 8 || out_diff !== e.d || out_borrow !== e.b || e.d !== 8'd7) begin
            failures++;
            $display("FAIL midrun_next: lat=%0d diff=%0d borrow=%b, want lat=8 diff=%0d borrow=%b",
                     cyc, out_diff, out_borrow, e.d, e.b);
        end
        take();
    endtask

    task automatic test_width1();
        logic [0:0] av[3] = '{1'b1, 1'b0, 1'b1};
        logic [0:0] bv[3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0] e;
        for (int k = 0; k < 3; k++) begin
            int cyc = 0;
            in_min1   = av[k];
            in_sub1   = bv[k];
            in_valid1 = 1'b1;
            sb1.push_back({1'(av[k] - bv[k]), (av[k] < bv[k])});
            @(negedge clk);
            in_valid1 = 1'b0;
            while (!out_valid1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            e = sb1.pop_front();
            checks++;
            if (cyc !== 1 || out_diff1 !== e[1] || out_borrow1 !== e[0]) begin
                failures++;
                $display("FAIL w1_%0d_%0d: lat=%0d diff=%0d borrow=%b, want lat=1 diff=%0d borrow=%b",
                         av[k], bv[k], cyc, out_diff1, out_borrow1, e[1], e[0]);
            end
            in_ready1 = 1'b1;
            @(negedge clk);
            in_ready1 = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ready  = 1'b0;
        in_min    = 8'd0;
        in_sub    = 8'd0;
        in_valid1 = 1'b0;
        in_ready1 = 1'b0;
        in_min1   = 1'b0;
        in_sub1   = 1'b0;
        test_reset();
        test_basic();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial unsigned subtractor, the inverse of the combinational summing blocks. It recovers one addend from a sum by computing OUT_diff = IN_minuend - IN_subtrahend, one bit per cycle, LSB first, with a single borrow flop. It sits behind a valid/ready producer and in front of a valid/ready consumer. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
IN_valid  input  1  upstream operands valid
OUT_ready  output  1  block can accept operands
IN_minuend  input  WIDTH  minuend, unsigned
IN_subtrahend  input  WIDTH  subtrahend, unsigned
OUT_valid  output  1  result valid
IN_ready  input  1  downstream accepts result
OUT_diff  output  WIDTH  difference, modulo 2^WIDTH
OUT_borrow  output  1  final borrow; 1 iff minuend < subtrahend (unsigned)

Behaviour:
- One clock domain (clk).
- rst asserted (async, active-high):
  - FSM to IDLE; borrow, count, operand and result registers cleared.
  - Output values while in reset: OUT_valid=0, OUT_ready=1, OUT_diff=0, OUT_borrow=0.
- FSM states:
  - IDLE:
    - OUT_ready=1, OUT_valid=0.
    - Accept on a rising edge where IN_valid && OUT_ready.
    - On accept: latch both operands into shift registers, borrow=0, count=0, go to RUN.
  - RUN:
    - OUT_ready=0, OUT_valid=0.
    - Each edge, with a=min_sh[0], b=sub_sh[0], br=borrow:
      - d = a^b^br
      - borrow' = (~a&b) | (~(a^b)&br)
    - Both operand shift registers shift right by 1.
    - Result register shifts right with d entering at bit WIDTH-1.
    - count increments.
    - When count reaches WIDTH-1 on an edge, go to DONE on that same edge. Exactly WIDTH RUN edges in total.
  - DONE:
    - OUT_valid=1; OUT_diff and OUT_borrow are the registered result.
    - OUT_ready=0.
    - On an edge with IN_ready=1: go to IDLE. OUT_valid drops the next cycle; OUT_diff and OUT_borrow hold their last value until the next DONE.
- Latency:
  - Accept edge = E0. OUT_valid rises after edge E0+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN edges, handshake).
- Handshake rules:
  - No new operand accepted outside IDLE; IN_valid in RUN/DONE is ignored and not stored.
  - The upstream must hold its data until accepted.
  - While IN_ready=0 in DONE: OUT_valid, OUT_diff and OUT_borrow are stable (no change of any kind).
  - OUT_valid must not depend combinationally on IN_ready.
  - OUT_ready is registered-state decode only, with no combinational path from IN_valid.
- Arithmetic:
  - Result equals (minuend - subtrahend) mod 2^WIDTH.
  - OUT_borrow equals the final borrow flop.
  - count width is $clog2(WIDTH+1).
- Boundary conditions:
  - WIDTH=1: a single RUN edge.
  - minuend == subtrahend: diff=0, borrow=0.
  - 0 - (2^WIDTH-1): diff=1, borrow=1.
- Reset mid-operation (RUN or DONE): in-flight result discarded, no OUT_valid pulse; block is in IDLE with OUT_ready=1 immediately (async).
- X/Z on operand inputs while not accepting must not affect state.

Test Plan:
- WIDTH=8, reset then accept 200, 55 -> OUT_valid after exactly 8 edges post-accept; OUT_diff=145, OUT_borrow=0; OUT_ready=0 from accept until handshake.
- WIDTH=8, operands 5, 7 -> OUT_diff=254 (0xFE), OUT_borrow=1. Operands 0, 255 -> OUT_diff=1, OUT_borrow=1. Operands 255, 255 -> OUT_diff=0, OUT_borrow=0.
- Backpressure: hold IN_ready=0 for 10 cycles in DONE, toggling IN_valid and the operands -> outputs constant, no second accept. Release IN_ready -> IDLE next cycle, then a new accept is possible.
- Back-to-back: IN_valid held high with 3 queued operand pairs (100-1, 1-100, 128-128) -> results 99/0, 157/1, 0/0, each issued WIDTH+2 cycles apart.
- Reset mid-RUN at cycle 4 of 8 -> OUT_valid never asserts for that transaction. OUT_ready=1, OUT_diff=0, OUT_borrow=0 before the next clk edge. Next transaction 10-3 -> 7/0.
- WIDTH=1 instance: 1-0 -> 1/0; 0-1 -> 1/1; result valid 1 edge after accept.
